if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues one instruction-memory request at a time over an addr_ok/data_ok handshake.
- Holds each returned instruction until the IF/ID stage accepts it.
- Applies branch/exception redirects and squashes any wrong-path fetch still in flight.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch PC loaded on reset.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
clk  input  1  clock
rsta  input  1  reset, asynchronous, active-high
allow_in  input  1  IF/ID accepts this cycle when high
redirect  input  1  one-cycle pulse: branch/exception redirect
redirect_pc  input  32  redirect target, valid with redirect
inst_req  output  1  memory request valid
inst_addr  output  32  request address
inst_addr_ok  input  1  memory accepted the request this cycle
inst_data_ok  input  1  read data returned this cycle
inst_rdata  input  32  returned instruction
valid_out  output  1  instruction valid toward IF/ID
pc_out  output  32  PC of the delivered instruction
instr_out  output  32  delivered instruction
exc_adel  output  1  address-error flag for the delivered instruction (see optional feature)

Behaviour:
- Reset (async):
  - state=REQ, fetch_pc=RESET_PC, cancel=0.
  - valid_out=0, pc_out=0, instr_out=0, exc_adel=0.
  - inst_req goes high in the first cycle after reset release.
- All outputs are registered except inst_req and inst_addr, which are decoded from state: inst_req=1 only in REQ; inst_addr=fetch_pc.
- One outstanding request maximum. A new request is never issued before the previous data_ok.
- State REQ:
  - addr_ok=1 -> WAIT; fetch_pc<=fetch_pc+PC_STEP.
  - If redirect is also high that cycle, set cancel=1 and fetch_pc<=redirect_pc instead.
  - addr_ok=0 with redirect -> fetch_pc<=redirect_pc, stay in REQ; the address changes the next cycle.
- State WAIT (data_ok may arrive any cycle from the one after acceptance onward):
  - data_ok with (cancel or redirect) -> drop the data, cancel<=0, go to REQ. Apply redirect_pc if redirect is high.
  - data_ok otherwise -> capture pc_out=fetch_pc-PC_STEP and instr_out=inst_rdata; valid_out<=1; go to OUT.
  - Redirect without data_ok -> cancel<=1, fetch_pc<=redirect_pc, stay in WAIT.
- State OUT:
  - pc_out and instr_out are held stable while allow_in=0.
  - allow_in=1 -> transfer; valid_out<=0, go to REQ. If redirect is high in the same cycle, the instruction still transfers and fetch_pc<=redirect_pc.
  - redirect with allow_in=0 -> squash: valid_out<=0, fetch_pc<=redirect_pc, go to REQ.
- Redirect priority is always over sequential increment.
- Delay-slot ordering is the redirect source's responsibility. It raises redirect only after the delay slot has left this stage.
- Throughput: at most one instruction per 3 cycles (REQ->WAIT->OUT). Minimum latency: 2 cycles from request to valid_out.
- PC arithmetic is 32-bit modulo. 0xFFFFFFFC+4 wraps to 0 silently.
- Reset asserted mid-WAIT: state returns to REQ, and a data_ok arriving after release while cancel=0 in REQ is ignored. Memory must flush on rsta.

Optional Feature:
- Macro: IF_ADEL_EN.
- Defined:
  - In REQ, if fetch_pc[1:0]!=0, no request is issued (inst_req=0).
  - The stage goes directly to OUT with valid_out=1, pc_out=fetch_pc, instr_out=32'h0, exc_adel=1.
  - exc_adel clears when the instruction transfers or is squashed.
- Undefined: exc_adel is tied 0 and misaligned addresses are issued unchanged.

Decomposition:
- Shared package/header holds: state encodings (REQ=2'd0, WAIT=2'd1, OUT=2'd2), NOP_INSTR=32'h0, and the RESET_PC default for reuse by IF/ID and the exception unit.
- No sub-module; the PC incrementer is a single adder inline.

Test Plan:
- Reset release, addr_ok and data_ok each one cycle after request, allow_in=1 -> inst_addr sequence BFC00000, BFC00004, BFC00008; valid_out pulses with matching pc_out.
- allow_in=0 for 5 cycles in OUT -> pc_out/instr_out stable, inst_req=0, no new request; resumes at pc_out+4 once allow_in=1.
- Redirect to 0x80001000 in WAIT, data_ok 2 cycles later with 0x12345678 -> data dropped, valid_out stays 0, next inst_addr=0x80001000.
- Redirect in REQ with addr_ok=0 (addr_ok held low 3 cycles) -> inst_addr switches to target next cycle, old address never accepted.
- Redirect with allow_in=1 in OUT -> current instruction transfers once; next request uses the target.
- IF_ADEL_EN defined, redirect to 0x80000002 -> no inst_req; valid_out=1, pc_out=0x80000002, instr_out=0, exc_adel=1.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Fetch-stage shared types and constants, reused by IF/ID and the exception unit.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  function automatic logic misaligned(
    input logic [31:0] pc
  );
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: redirect, IF/ID hand-off and instruction-memory handshake.
interface if_fetch_stage_if;

  logic        allow_in;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        exc_adel;

  modport master (
    input  allow_in,
    input  redirect,
    input  redirect_pc,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata,
    output inst_req,
    output inst_addr,
    output valid_out,
    output pc_out,
    output instr_out,
    output exc_adel
  );

  modport slave (
    output allow_in,
    output redirect,
    output redirect_pc,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata,
    input  inst_req,
    input  inst_addr,
    input  valid_out,
    input  pc_out,
    input  instr_out,
    input  exc_adel
  );

endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding fetch, redirect/squash, IF/ID hold.
// IF_ADEL_EN: misaligned fetch PCs deliver an address-error slot instead of a request.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rsta,
  if_fetch_stage_if.master  bus
);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic         cancel_q;
  logic         valid_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         exc_q;

  logic [31:0]  pc_inc;
  logic [31:0]  pc_prev;
  logic         fault;

  assign pc_inc  = fetch_pc_q + PC_STEP;
  assign pc_prev = fetch_pc_q - PC_STEP;

`ifdef IF_ADEL_EN
  assign fault = misaligned(fetch_pc_q);
`else
  assign fault = 1'b0;
`endif

  assign bus.inst_req  = (state_q == REQ) && !fault;
  assign bus.inst_addr = fetch_pc_q;
  assign bus.valid_out = valid_q;
  assign bus.pc_out    = pc_q;
  assign bus.instr_out = instr_q;
  assign bus.exc_adel  = exc_q;

  always_ff @(posedge clk or posedge rsta) begin
    if (rsta) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      cancel_q   <= 1'b0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
      exc_q      <= 1'b0;
    end else begin
      unique case (state_q)
        REQ: begin
          if (fault) begin
            if (bus.redirect) begin
              fetch_pc_q <= bus.redirect_pc;
            end else begin
              state_q <= OUT;
              valid_q <= 1'b1;
              pc_q    <= fetch_pc_q;
              instr_q <= NOP_INSTR;
              exc_q   <= 1'b1;
            end
          end else if (bus.inst_addr_ok) begin
            state_q  <= WAIT;
            cancel_q <= bus.redirect;
            fetch_pc_q <= bus.redirect ?
                          bus.redirect_pc : pc_inc;
          end else if (bus.redirect) begin
            fetch_pc_q <= bus.redirect_pc;
          end
        end

        WAIT: begin
          // fetch_pc already points past the in-flight word
          if (bus.inst_data_ok) begin
            if (cancel_q || bus.redirect) begin
              cancel_q <= 1'b0;
              state_q  <= REQ;
            end else begin
              state_q <= OUT;
              valid_q <= 1'b1;
              pc_q    <= pc_prev;
              instr_q <= bus.inst_rdata;
              exc_q   <= 1'b0;
            end
          end else if (bus.redirect) begin
            cancel_q <= 1'b1;
          end
          if (bus.redirect) begin
            fetch_pc_q <= bus.redirect_pc;
          end
        end

        OUT: begin
          if (bus.allow_in || bus.redirect) begin
            state_q <= REQ;
            valid_q <= 1'b0;
            exc_q   <= 1'b0;
          end
          if (bus.redirect) begin
            fetch_pc_q <= bus.redirect_pc;
          end
        end

        default: begin
          state_q <= REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised bench for if_fetch_stage against a transaction-level fetch model.
// Add +define+IF_ADEL_EN to exercise the address-error slot.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

`ifdef IF_ADEL_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  logic clk;
  logic rsta;

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .RESET_PC (RESET_PC_DEF),
    .PC_STEP  (32'd4)
  ) dut (
    .clk  (clk),
    .rsta (rsta),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic        m_busy;
  logic        m_live;
  logic        e_v;
  logic [31:0] e_pc;
  logic [31:0] e_ins;
  logic        e_exc;
  logic        e_req;

  int p_aok, p_dok, p_alw, p_rd;
  bit          f_rd;
  logic [31:0] f_rpc;
  bit          stray;

  logic [31:0] acc_q[$];
  logic [31:0] xfer_q[$];
  int          n_xfer;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic logic [31:0] rnd_target();
    logic [31:0] t;
    int r;
    r = $urandom_range(0, 99);
    t = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
    if (r < 8) t = 32'hFFFF_FFF8;
    else if (r < 16) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic idle_inputs();
    bus.allow_in     = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
  endtask

  // One clock: check what the last edge produced, drive, advance the model.
  task automatic cycle();
    logic aok, dok, alw, rd, busy0, v0, mis0;
    logic [31:0] rpc;
    @(negedge clk);
    chk("valid_out", 32'(bus.valid_out), 32'(e_v));
    if (e_v) begin
      chk("pc_out", bus.pc_out, e_pc);
      chk("instr_out", bus.instr_out, e_ins);
    end
    chk("exc_adel", 32'(bus.exc_adel), 32'(e_exc));
    chk("inst_req", 32'(bus.inst_req), 32'(e_req));
    if (e_req) chk("inst_addr", bus.inst_addr, m_pc);

    busy0 = m_busy;
    v0    = e_v;
    mis0  = ADEL && !busy0 && !v0 && (m_pc[1:0] != 2'b00);
    aok   = e_req && ($urandom_range(0, 99) < p_aok);
    dok   = busy0 && ($urandom_range(0, 99) < p_dok);
    if (stray) begin
      aok = 1'b0;
      dok = 1'b1;
    end
    alw = $urandom_range(0, 99) < p_alw;
    rd  = f_rd || ($urandom_range(0, 99) < p_rd);
    rpc = f_rd ? f_rpc : rnd_target();
    f_rd  = 1'b0;
    stray = 1'b0;

    bus.allow_in     = alw;
    bus.redirect     = rd;
    bus.redirect_pc  = rd ? rpc : $urandom;
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = (dok && busy0) ? memf(m_addr) : $urandom;

    if (bus.valid_out && alw) begin
      n_xfer++;
      xfer_q.push_back(bus.pc_out);
    end

    if (dok && busy0 && m_live && !rd) begin
      e_v = 1'b1; e_pc = m_addr; e_ins = memf(m_addr); e_exc = 1'b0;
    end else if (v0 && !alw && !rd) begin
      e_v = 1'b1;
    end else if (mis0 && !rd) begin
      e_v = 1'b1; e_pc = m_pc; e_ins = NOP_INSTR; e_exc = 1'b1;
    end else begin
      e_v = 1'b0; e_exc = 1'b0;
    end

    if (dok) m_busy = 1'b0;
    if (rd) m_live = 1'b0;
    if (aok) begin
      m_busy = 1'b1;
      m_addr = m_pc;
      m_live = !rd;
      acc_q.push_back(m_pc);
      if (!rd) m_pc = m_pc + 32'd4;
    end
    if (rd) m_pc = rpc;
    e_req = !m_busy && !e_v && !(ADEL && m_pc[1:0] != 2'b00);
  endtask

  task automatic do_reset(input bit with_stray);
    @(negedge clk);
    rsta = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("rst_valid_out", 32'(bus.valid_out), 32'h0);
    chk("rst_pc_out", bus.pc_out, 32'h0);
    chk("rst_instr_out", bus.instr_out, 32'h0);
    chk("rst_exc_adel", 32'(bus.exc_adel), 32'h0);
    rsta   = 1'b0;
    m_pc   = RESET_PC_DEF;
    m_addr = '0;
    m_busy = 1'b0;
    m_live = 1'b0;
    e_v    = 1'b0;
    e_pc   = '0;
    e_ins  = '0;
    e_exc  = 1'b0;
    e_req  = 1'b1;
    acc_q.delete();
    xfer_q.delete();
    stray  = with_stray;
  endtask

  // kind 0: next cycle delivers, 1: next cycle waits on memory, 2: next cycle requests
  task automatic run_until(input int kind, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      case (kind)
        0:       hit = e_v;
        1:       hit = m_busy;
        default: hit = e_req;
      endcase
      if (hit) break;
      cycle();
    end
    chk(tag, 32'(hit), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_pc;
    int n;
    checks = 0;
    errors = 0;
    n_xfer = 0;
    f_rd   = 1'b0;
    f_rpc  = '0;
    stray  = 1'b0;
    rsta   = 1'b1;
    idle_inputs();

    p_aok = 100; p_dok = 100; p_alw = 100; p_rd = 0;
    do_reset(1'b0);

    repeat (9) cycle();
    chk("seq_addr0", acc_q[0], 32'hBFC0_0000);
    chk("seq_addr1", acc_q[1], 32'hBFC0_0004);
    chk("seq_addr2", acc_q[2], 32'hBFC0_0008);
    chk("seq_xfer0", xfer_q[0], 32'hBFC0_0000);
    chk("seq_xfer2", xfer_q[2], 32'hBFC0_0008);

    p_alw = 0;
    run_until(0, "stall_wait_valid");
    repeat (5) cycle();
    hold_pc = e_pc;
    p_alw = 100;
    run_until(2, "stall_wait_req");
    cycle();
    chk("stall_resume_addr", acc_q[$], hold_pc + 32'd4);

    run_until(1, "rdw_wait_busy");
    n = n_xfer;
    p_dok = 0;
    f_rd = 1'b1; f_rpc = 32'h8000_1000;
    cycle();
    cycle();
    p_dok = 100;
    cycle();
    run_until(2, "rdw_wait_req");
    cycle();
    chk("rdw_next_addr", acc_q[$], 32'h8000_1000);
    chk("rdw_no_xfer", 32'(n_xfer), 32'(n));

    run_until(2, "rdq_wait_req");
    p_aok = 0;
    f_rd = 1'b1; f_rpc = 32'h8000_2000;
    cycle();
    n = acc_q.size();
    repeat (2) cycle();
    p_aok = 100;
    cycle();
    chk("rdq_accept_cnt", 32'(acc_q.size()), 32'(n + 1));
    chk("rdq_accept_addr", acc_q[$], 32'h8000_2000);

    run_until(0, "rdo_wait_valid");
    n = n_xfer;
    hold_pc = e_pc;
    f_rd = 1'b1; f_rpc = 32'h8000_3000;
    cycle();
    chk("rdo_xfer_cnt", 32'(n_xfer), 32'(n + 1));
    chk("rdo_xfer_pc", xfer_q[$], hold_pc);
    run_until(2, "rdo_wait_req");
    cycle();
    chk("rdo_next_addr", acc_q[$], 32'h8000_3000);

`ifdef IF_ADEL_EN
    run_until(2, "adel_wait_req");
    p_aok = 0; p_alw = 0;
    f_rd = 1'b1; f_rpc = 32'h8000_0002;
    cycle();
    cycle();
    cycle();
    chk("adel_valid", 32'(bus.valid_out), 32'h1);
    chk("adel_pc", bus.pc_out, 32'h8000_0002);
    chk("adel_instr", bus.instr_out, 32'h0);
    chk("adel_exc", 32'(bus.exc_adel), 32'h1);
    f_rd = 1'b1; f_rpc = 32'h8000_4000;
    p_aok = 100; p_alw = 100;
    cycle();
`endif

    p_aok = 60; p_dok = 50; p_alw = 60; p_rd = 6;
    n_xfer = 0;
    for (int i = 0; i < 4000; i++) begin
      cycle();
      if (m_busy && $urandom_range(0, 999) < 3) begin
        do_reset(1'b1);
      end
    end
    chk("rand_progress", 32'(n_xfer > 200), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
